// File: rtl/pe_config_loader.sv
// Configuration loader for the PE array. Words are assembled into a shadow copy of
// the active configuration, and the whole shadow is committed when the array is idle.
module pe_config_loader #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned CONFIG_W = 128,
  parameter int unsigned ROWS     = 4,
  localparam int unsigned WPR     = CONFIG_W / WORD_W,
  localparam int unsigned H_C_W   = ROWS * CONFIG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [ROWS-1:0]   cfg_row_mask,
  input  logic              cfg_abort,
  input  logic              cfg_word_valid,
  input  logic [WORD_W-1:0] cfg_word,
  output logic              cfg_word_ready,
  input  logic              array_idle,
  output logic [H_C_W-1:0]  pe_config,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_error
);

  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned WCW = (WPR > 1) ? $clog2(WPR) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_e;

  state_e            state_q, state_d;
  logic [H_C_W-1:0]  shadow_q, shadow_d;
  logic [H_C_W-1:0]  cfg_q, cfg_d;
  logic [ROWS-1:0]   mask_q, mask_d;
  logic [RW-1:0]     row_q, row_d;
  logic [WCW-1:0]    word_q, word_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [RW-1:0]     first_row, next_row;
  logic              has_next;
  int unsigned       wr_base;

  // Descending scan so the last hit is the lowest qualifying row.
  always_comb begin
    first_row = '0;
    next_row  = '0;
    has_next  = 1'b0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (cfg_row_mask[ROWS-1-i]) first_row = RW'(ROWS-1-i);
      if (mask_q[ROWS-1-i] && ((ROWS-1-i) > 32'(row_q))) begin
        next_row = RW'(ROWS-1-i);
        has_next = 1'b1;
      end
    end
  end

  assign wr_base = 32'(row_q) * CONFIG_W + 32'(word_q) * WORD_W;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    mask_d   = mask_q;
    row_d    = row_q;
    word_d   = word_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_row_mask == '0) begin
            error_d = 1'b1;
          end else begin
            shadow_d = cfg_q;
            mask_d   = cfg_row_mask;
            row_d    = first_row;
            word_d   = '0;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        error_d = cfg_start;
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (cfg_word_valid) begin
          shadow_d[wr_base +: WORD_W] = cfg_word;
          if (word_q == WCW'(WPR-1)) begin
            word_d = '0;
            if (has_next) row_d = next_row;
            else          state_d = PEND;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      PEND: begin
        error_d = cfg_start;
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (array_idle) begin
          cfg_d   = shadow_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cfg_q    <= '0;
      mask_q   <= '0;
      row_q    <= '0;
      word_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      mask_q   <= mask_d;
      row_q    <= row_d;
      word_q   <= word_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign pe_config      = cfg_q;
  assign cfg_busy       = (state_q != IDLE);
  assign cfg_word_ready = (state_q == LOAD);
  assign cfg_done       = done_q;
  assign cfg_error      = error_q;

endmodule

// File: tb/tb_pe_config_loader.sv
// Bench for pe_config_loader: directed scenarios plus randomized loads checked
// against a row/word reference model of the expected configuration.
module tb_pe_config_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start;
  logic [3:0]   cfg_row_mask;
  logic         cfg_abort;
  logic         cfg_word_valid;
  logic [31:0]  cfg_word;
  logic         cfg_word_ready;
  logic         array_idle;
  logic [511:0] pe_config;
  logic         cfg_busy;
  logic         cfg_done;
  logic         cfg_error;

  int tests = 0;
  int fails = 0;
  logic [511:0] mdl;
  logic [31:0]  wbuf [16];

  pe_config_loader #(.WORD_W(32), .CONFIG_W(128), .ROWS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_row_mask   (cfg_row_mask),
    .cfg_abort      (cfg_abort),
    .cfg_word_valid (cfg_word_valid),
    .cfg_word       (cfg_word),
    .cfg_word_ready (cfg_word_ready),
    .array_idle     (array_idle),
    .pe_config      (pe_config),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .cfg_error      (cfg_error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkr(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected configuration: masked rows ascending, words LSB-first, taken from wbuf in order.
  function automatic logic [511:0] apply(input logic [511:0] base, input logic [3:0] m);
    int n = 0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (m[r]) begin
          base[r*128 + k*32 +: 32] = wbuf[n];
          n++;
        end
    return base;
  endfunction

  task automatic rst_check(input string tag);
    chkw({tag, "_cfg"}, pe_config, '0);
    chk1({tag, "_busy"}, int'(cfg_busy), 0);
    chk1({tag, "_ready"}, int'(cfg_word_ready), 0);
    chk1({tag, "_done"}, int'(cfg_done), 0);
    chk1({tag, "_error"}, int'(cfg_error), 0);
  endtask

  // mode: 0 random, 1 all-A5, 2 all-11, 3 word index. inj >= 0 fires a stray start at that load cycle.
  task automatic run_load(input logic [3:0] m, input int mode, input bit gaps, input int inj,
                          output int acc, output int ncyc);
    int errs = 0;
    int dn = 0;
    logic [31:0] w;
    acc = 0;
    ncyc = 0;
    cfg_start = 1'b1;
    cfg_row_mask = m;
    tick;
    cfg_start = 1'b0;
    chk1("start_busy", int'(cfg_busy), 1);
    chk1("start_ready", int'(cfg_word_ready), 1);
    while (cfg_word_ready && ncyc < 300) begin
      case (mode)
        0: w = $urandom;
        1: w = 32'hA5A5A5A5;
        2: w = 32'h11111111;
        default: w = 32'(acc);
      endcase
      cfg_word = w;
      cfg_word_valid = !(gaps && $urandom_range(0, 2) == 0);
      if (ncyc == inj) begin
        cfg_start = 1'b1;
        cfg_row_mask = ~m;
      end
      if (cfg_word_valid) begin
        if (acc < 16) wbuf[acc] = w;
        acc++;
      end
      tick;
      ncyc++;
      cfg_start = 1'b0;
      if (cfg_error) errs++;
      if (cfg_done) dn++;
    end
    cfg_word_valid = 1'b0;
    chk1("load_budget", int'(ncyc < 300), 1);
    chk1("load_words", acc, 4 * $countones(m));
    chk1("load_errors", errs, (inj >= 0) ? 1 : 0);
    chk1("load_no_done", dn, 0);
    chk1("pend_ready", int'(cfg_word_ready), 0);
    chk1("pend_busy", int'(cfg_busy), 1);
  endtask

  task automatic commit(input int hold, input logic [511:0] exp_new);
    array_idle = 1'b0;
    repeat (hold) begin
      tick;
      chkw("hold_cfg", pe_config, mdl);
      chk1("hold_busy", int'(cfg_busy), 1);
      chk1("hold_ready", int'(cfg_word_ready), 0);
      chk1("hold_done", int'(cfg_done), 0);
    end
    array_idle = 1'b1;
    tick;
    chkw("commit_cfg", pe_config, exp_new);
    chk1("commit_done", int'(cfg_done), 1);
    chk1("commit_busy", int'(cfg_busy), 0);
    mdl = exp_new;
    array_idle = 1'b0;
    tick;
    chk1("done_pulse", int'(cfg_done), 0);
    chkw("post_cfg", pe_config, mdl);
  endtask

  task automatic full_seq;
    int acc, nc;
    array_idle = 1'b1;
    run_load(4'hF, 3, 1'b0, -1, acc, nc);
    chk1("full_cycles", nc, 16);
    commit(0, apply(mdl, 4'hF));
    chkr("full_row0", pe_config[127:0], 128'h00000003_00000002_00000001_00000000);
    chkr("full_row3", pe_config[511:384], 128'h0000000F_0000000E_0000000D_0000000C);
  endtask

  initial begin
    int acc, nc;
    logic [3:0] m;
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_row_mask = '0;
    cfg_abort = 1'b0;
    cfg_word_valid = 1'b0;
    cfg_word = '0;
    array_idle = 1'b0;
    mdl = '0;
    #3;
    rst_check("reset");
    tick;
    tick;
    rst = 1'b0;
    tick;

    full_seq();

    run_load(4'hF, 1, 1'b0, -1, acc, nc);
    commit(0, apply(mdl, 4'hF));
    chkw("preset_a5", pe_config, {16{32'hA5A5A5A5}});
    run_load(4'b0101, 2, 1'b0, -1, acc, nc);
    chk1("partial_words", acc, 8);
    commit(0, {{4{32'hA5A5A5A5}}, {4{32'h11111111}}, {4{32'hA5A5A5A5}}, {4{32'h11111111}}});

    m = 4'($urandom_range(1, 15));
    run_load(m, 0, 1'b1, -1, acc, nc);
    commit(10, apply(mdl, m));

    cfg_start = 1'b1;
    cfg_row_mask = 4'hF;
    tick;
    cfg_start = 1'b0;
    repeat (5) begin
      cfg_word_valid = 1'b1;
      cfg_word = $urandom;
      tick;
    end
    cfg_abort = 1'b1;
    tick;
    cfg_abort = 1'b0;
    cfg_word_valid = 1'b0;
    chk1("abort_load_busy", int'(cfg_busy), 0);
    chk1("abort_load_ready", int'(cfg_word_ready), 0);
    chkw("abort_load_cfg", pe_config, mdl);
    tick;
    chk1("abort_load_done", int'(cfg_done), 0);

    run_load(4'b1010, 0, 1'b0, -1, acc, nc);
    cfg_abort = 1'b1;
    array_idle = 1'b1;
    tick;
    cfg_abort = 1'b0;
    array_idle = 1'b0;
    chk1("abort_pend_busy", int'(cfg_busy), 0);
    chkw("abort_pend_cfg", pe_config, mdl);
    chk1("abort_pend_done", int'(cfg_done), 0);
    tick;
    chk1("abort_pend_done2", int'(cfg_done), 0);
    chkw("abort_pend_cfg2", pe_config, mdl);

    cfg_abort = 1'b1;
    tick;
    cfg_abort = 1'b0;
    chk1("abort_idle_busy", int'(cfg_busy), 0);

    cfg_start = 1'b1;
    cfg_row_mask = 4'h0;
    tick;
    cfg_start = 1'b0;
    chk1("zero_mask_error", int'(cfg_error), 1);
    chk1("zero_mask_busy", int'(cfg_busy), 0);
    tick;
    chk1("zero_mask_pulse", int'(cfg_error), 0);
    m = 4'($urandom_range(1, 15));
    run_load(m, 0, 1'b1, 2, acc, nc);
    commit(2, apply(mdl, m));

    cfg_start = 1'b1;
    cfg_row_mask = 4'hF;
    tick;
    cfg_start = 1'b0;
    cfg_word_valid = 1'b1;
    cfg_word = 32'hDEADBEEF;
    repeat (3) tick;
    #2 rst = 1'b1;
    #1 rst_check("rst_load");
    #1 rst = 1'b0;
    cfg_word_valid = 1'b0;
    mdl = '0;
    tick;

    run_load(4'h3, 0, 1'b0, -1, acc, nc);
    commit(0, apply(mdl, 4'h3));
    run_load(4'h6, 0, 1'b0, -1, acc, nc);
    #2 rst = 1'b1;
    #1 rst_check("rst_pend");
    #1 rst = 1'b0;
    mdl = '0;
    tick;
    full_seq();

    repeat (8) begin
      m = 4'($urandom_range(1, 15));
      run_load(m, 0, 1'b1, -1, acc, nc);
      commit(int'($urandom_range(0, 3)), apply(mdl, m));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
